// File: rtl/apb_rr_arbiter_if.sv
// Requester and APB-master signal bundle for apb_rr_arbiter.
// The master modport is the arbiter's view; slave is the environment's view.
interface apb_rr_arbiter_if #(
  parameter int unsigned NREQ   = 4,
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned DATA_W = 8
);
  logic [NREQ-1:0]        req;
  logic [NREQ-1:0]        req_rd;
  logic [NREQ*ADDR_W-1:0] req_addr;
  logic [NREQ*DATA_W-1:0] req_wdata;
  logic [NREQ-1:0]        gnt;
  logic [NREQ-1:0]        done;
  logic [DATA_W-1:0]      rdata;
  logic                   err;
  logic                   tmo;
  logic                   transfer;
  logic                   READ_WRITE;
  logic [ADDR_W-1:0]      apb_write_paddr;
  logic [DATA_W-1:0]      apb_write_data;
  logic [ADDR_W-1:0]      apb_read_paddr;
  logic                   m_done;
  logic                   PSLVERR;
  logic [DATA_W-1:0]      apb_read_data_out;

  modport master (
    input  req, req_rd, req_addr, req_wdata, m_done, PSLVERR, apb_read_data_out,
    output gnt, done, rdata, err, tmo, transfer, READ_WRITE,
           apb_write_paddr, apb_write_data, apb_read_paddr
  );

  modport slave (
    output req, req_rd, req_addr, req_wdata, m_done, PSLVERR, apb_read_data_out,
    input  gnt, done, rdata, err, tmo, transfer, READ_WRITE,
           apb_write_paddr, apb_write_data, apb_read_paddr
  );
endinterface

// File: rtl/apb_rr_arbiter.sv
// Round-robin arbiter sharing one APB master between NREQ requesters.
// Latches the winner's command, waits for completion or timeout, pulses done.
module apb_rr_arbiter #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned ADDR_W  = 9,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned TIMEOUT = 16
) (
  input logic                 PCLK,
  input logic                 PRESET,
  apb_rr_arbiter_if.master    bus
);
  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [NREQ-1:0]   gnt_q, gnt_d, done_q, done_d;
  logic [DATA_W-1:0] rdata_q, rdata_d, wdata_q, wdata_d;
  logic              err_q, err_d, tmo_q, tmo_d;
  logic              transfer_q, transfer_d, rw_q, rw_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  logic [PW-1:0]     idx_c, win_c;
  logic              any_c, rd_c;
  logic [ADDR_W-1:0] addr_c;
  logic [DATA_W-1:0] wd_c;

  // First requesting index after ptr, wrapping modulo NREQ
  always_comb begin
    any_c = 1'b0;
    win_c = '0;
    idx_c = '0;
    for (int i = 1; i <= int'(NREQ); i++) begin
      idx_c = PW'((int'(ptr_q) + i) % int'(NREQ));
      if (!any_c && bus.req[idx_c]) begin
        any_c = 1'b1;
        win_c = idx_c;
      end
    end
  end

  // Command of the current winner
  always_comb begin
    rd_c   = 1'b0;
    addr_c = '0;
    wd_c   = '0;
    for (int k = 0; k < int'(NREQ); k++) begin
      if (win_c == PW'(k)) begin
        rd_c   = bus.req_rd[k];
        addr_c = bus.req_addr[k*ADDR_W +: ADDR_W];
        wd_c   = bus.req_wdata[k*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    timer_d    = timer_q;
    gnt_d      = gnt_q;
    done_d     = '0;
    rdata_d    = rdata_q;
    err_d      = err_q;
    tmo_d      = tmo_q;
    transfer_d = transfer_q;
    rw_d       = rw_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    case (state_q)
      IDLE: begin
        gnt_d      = '0;
        transfer_d = 1'b0;
        rw_d       = 1'b0;
        addr_d     = '0;
        wdata_d    = '0;
        if (any_c) begin
          state_d    = XFER;
          ptr_d      = win_c;
          timer_d    = '0;
          gnt_d      = NREQ'(1) << win_c;
          transfer_d = 1'b1;
          rw_d       = rd_c;
          addr_d     = addr_c;
          wdata_d    = wd_c;
        end
      end
      XFER: begin
        timer_d = timer_q + 1'b1;
        // A completion in the timeout cycle still counts as a normal completion
        if (bus.m_done || (timer_q == TW'(TIMEOUT - 1))) begin
          state_d    = DONE;
          done_d     = NREQ'(1) << ptr_q;
          gnt_d      = '0;
          transfer_d = 1'b0;
          rw_d       = 1'b0;
          addr_d     = '0;
          wdata_d    = '0;
          if (bus.m_done) begin
            err_d = bus.PSLVERR;
            tmo_d = 1'b0;
            if (rw_q) rdata_d = bus.apb_read_data_out;
          end else begin
            err_d = 1'b1;
            tmo_d = 1'b1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q    <= IDLE;
      ptr_q      <= PW'(NREQ - 1);
      timer_q    <= '0;
      gnt_q      <= '0;
      done_q     <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      tmo_q      <= 1'b0;
      transfer_q <= 1'b0;
      rw_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      timer_q    <= timer_d;
      gnt_q      <= gnt_d;
      done_q     <= done_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
      tmo_q      <= tmo_d;
      transfer_q <= transfer_d;
      rw_q       <= rw_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
    end
  end

  assign bus.gnt             = gnt_q;
  assign bus.done            = done_q;
  assign bus.rdata           = rdata_q;
  assign bus.err             = err_q;
  assign bus.tmo             = tmo_q;
  assign bus.transfer        = transfer_q;
  assign bus.READ_WRITE      = rw_q;
  assign bus.apb_write_paddr = addr_q;
  assign bus.apb_read_paddr  = addr_q;
  assign bus.apb_write_data  = wdata_q;
endmodule

// File: tb/tb_apb_rr_arbiter.sv
// Directed bench for apb_rr_arbiter; the bench plays requesters and the APB master.
module tb_apb_rr_arbiter;
  localparam int NREQ = 4;
  localparam int AW   = 9;
  localparam int DW   = 8;

  logic PCLK;
  logic PRESET;
  int   n_tests = 0;
  int   n_fail  = 0;

  apb_rr_arbiter_if #(.NREQ(NREQ), .ADDR_W(AW), .DATA_W(DW)) bus ();

  apb_rr_arbiter #(.NREQ(NREQ), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(16)) dut (
    .PCLK   (PCLK),
    .PRESET (PRESET),
    .bus    (bus)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic set_cmd(input int k, input logic rd, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.req_rd[k]                = rd;
    bus.req_addr[k*AW +: AW]     = a;
    bus.req_wdata[k*DW +: DW]    = d;
  endtask

  // Wait for transfer, drive m_done in XFER cycle lat_m (or never), check the done pulse.
  task automatic serve(input int lat_m, input logic give_done, input logic slverr,
                       input logic [DW-1:0] rd_in, output logic [NREQ-1:0] g, output int ncyc);
    int n;
    n = 0;
    while (bus.transfer !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check_eq("transfer_seen", 32'(bus.transfer), 32'd1);
    g = bus.gnt;
    check_eq("gnt_onehot", 32'($countones(g)), 32'd1);
    ncyc = 1;
    while (bus.done === '0 && ncyc < 40) begin
      if (give_done && ncyc == lat_m) begin
        bus.m_done            = 1'b1;
        bus.PSLVERR           = slverr;
        bus.apb_read_data_out = rd_in;
      end
      tick();
      bus.m_done            = 1'b0;
      bus.PSLVERR           = 1'b0;
      bus.apb_read_data_out = '0;
      if (bus.done === '0) ncyc++;
    end
    check_eq("done_to_winner", 32'(bus.done), 32'(g));
    check_eq("done_gnt_low", 32'(bus.gnt), 32'd0);
    check_eq("done_transfer_low", 32'(bus.transfer), 32'd0);
    tick();
    check_eq("done_one_cycle", 32'(bus.done), 32'd0);
  endtask

  logic [NREQ-1:0] g;
  int              nc;

  initial begin
    PRESET                = 1'b1;
    bus.req               = '0;
    bus.req_rd            = '0;
    bus.req_addr          = '0;
    bus.req_wdata         = '0;
    bus.m_done            = 1'b0;
    bus.PSLVERR           = 1'b0;
    bus.apb_read_data_out = '0;
    tick();
    tick();
    check_eq("rst_gnt", 32'(bus.gnt), 32'd0);
    check_eq("rst_done", 32'(bus.done), 32'd0);
    check_eq("rst_transfer", 32'(bus.transfer), 32'd0);
    check_eq("rst_rdata_err_tmo", {bus.rdata, bus.err, bus.tmo}, 32'd0);
    PRESET = 1'b0;
    tick();

    // Single write from requester 1
    set_cmd(1, 1'b0, 9'h005, 8'hAA);
    bus.req = 4'b0010;
    tick();
    check_eq("wr_latency", 32'(bus.transfer), 32'd1);
    check_eq("wr_gnt", 32'(bus.gnt), 32'h2);
    check_eq("wr_dir", 32'(bus.READ_WRITE), 32'd0);
    check_eq("wr_paddr", 32'(bus.apb_write_paddr), 32'h005);
    check_eq("wr_data", 32'(bus.apb_write_data), 32'hAA);
    serve(3, 1'b1, 1'b0, 8'h00, g, nc);
    bus.req = '0;
    check_eq("wr_mdone_to_done", 32'(nc), 32'd3);
    check_eq("wr_err", {bus.err, bus.tmo}, 32'd0);

    // Read to slave 2 from requester 0
    set_cmd(0, 1'b1, 9'h103, 8'h00);
    bus.req = 4'b0001;
    tick();
    check_eq("rd_dir", 32'(bus.READ_WRITE), 32'd1);
    check_eq("rd_paddr", 32'(bus.apb_read_paddr), 32'h103);
    check_eq("rd_gnt", 32'(bus.gnt), 32'h1);
    serve(2, 1'b1, 1'b0, 8'h3C, g, nc);
    bus.req = '0;
    check_eq("rd_rdata", 32'(bus.rdata), 32'h3C);
    check_eq("rd_err_tmo", {bus.err, bus.tmo}, 32'd0);

    // Slave error on a write: rdata must keep the last read value
    set_cmd(2, 1'b0, 9'h010, 8'h11);
    bus.req = 4'b0100;
    serve(1, 1'b1, 1'b1, 8'hFF, g, nc);
    bus.req = '0;
    check_eq("slverr_err_tmo", {bus.err, bus.tmo}, 32'b10);
    check_eq("slverr_rdata", 32'(bus.rdata), 32'h3C);

    // Timeout on a read: no m_done at all
    set_cmd(3, 1'b1, 9'h120, 8'h00);
    bus.req = 4'b1000;
    serve(0, 1'b0, 1'b0, 8'h00, g, nc);
    bus.req = '0;
    check_eq("tmo_cycles", 32'(nc), 32'd16);
    check_eq("tmo_err_tmo", {bus.err, bus.tmo}, 32'b11);
    check_eq("tmo_rdata", 32'(bus.rdata), 32'h3C);

    // Fairness: all requesting, pointer is at 3 so order is 0,1,2,3
    for (int k = 0; k < NREQ; k++) set_cmd(k, 1'b0, 9'(k), 8'(k));
    bus.req = 4'b1111;
    serve(1, 1'b1, 1'b0, 8'h00, g, nc);
    check_eq("rr_0", 32'(g), 32'h1);
    serve(1, 1'b1, 1'b0, 8'h00, g, nc);
    check_eq("rr_1", 32'(g), 32'h2);
    serve(1, 1'b1, 1'b0, 8'h00, g, nc);
    check_eq("rr_2", 32'(g), 32'h4);
    serve(1, 1'b1, 1'b0, 8'h00, g, nc);
    check_eq("rr_3", 32'(g), 32'h8);
    bus.req = 4'b1001;
    serve(1, 1'b1, 1'b0, 8'h00, g, nc);
    check_eq("rr_1001_first", 32'(g), 32'h1);
    serve(1, 1'b1, 1'b0, 8'h00, g, nc);
    check_eq("rr_1001_second", 32'(g), 32'h8);
    bus.req = '0;

    // Command change and req drop during XFER must not disturb the transfer
    set_cmd(2, 1'b0, 9'h044, 8'h55);
    bus.req = 4'b0100;
    tick();
    set_cmd(2, 1'b1, 9'h1FF, 8'h00);
    bus.req = '0;
    tick();
    tick();
    check_eq("frz_transfer", 32'(bus.transfer), 32'd1);
    check_eq("frz_gnt", 32'(bus.gnt), 32'h4);
    check_eq("frz_dir", 32'(bus.READ_WRITE), 32'd0);
    check_eq("frz_waddr", 32'(bus.apb_write_paddr), 32'h044);
    check_eq("frz_raddr", 32'(bus.apb_read_paddr), 32'h044);
    check_eq("frz_wdata", 32'(bus.apb_write_data), 32'h55);
    serve(1, 1'b1, 1'b0, 8'h00, g, nc);
    check_eq("frz_done_grant", 32'(g), 32'h4);

    // Reset in XFER, then pointer back at NREQ-1
    set_cmd(1, 1'b0, 9'h0AB, 8'hCD);
    bus.req = 4'b0010;
    tick();
    tick();
    check_eq("prst_in_xfer", 32'(bus.transfer), 32'd1);
    PRESET = 1'b1;
    tick();
    check_eq("prst_gnt_done", {bus.gnt, bus.done}, 32'd0);
    check_eq("prst_transfer_dir", {bus.transfer, bus.READ_WRITE}, 32'd0);
    check_eq("prst_addr_data", {bus.apb_write_paddr, bus.apb_write_data}, 32'd0);
    check_eq("prst_rdata_err_tmo", {bus.rdata, bus.err, bus.tmo}, 32'd0);
    PRESET  = 1'b0;
    bus.req = 4'b0110;
    tick();
    check_eq("prst_next_gnt", 32'(bus.gnt), 32'h2);
    check_eq("prst_no_done", 32'(bus.done), 32'd0);
    bus.req = '0;
    serve(1, 1'b1, 1'b0, 8'h00, g, nc);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/apb_rr_arbiter.md
Name: apb_rr_arbiter

Overview:
- Round-robin arbiter and sequencer sharing the single APB master (APB_Protocol) between NREQ requesters.
- Latches the winning requester's command and drives the master's transfer, READ_WRITE, address and data inputs.
- Waits for access completion or timeout, then returns read data and error status to the winner with a one-cycle done pulse.

Parameters:
NREQ, 4, number of requesters (2..8)
ADDR_W, 9, APB address width; bit ADDR_W-1 selects slave
DATA_W, 8, APB data width
TIMEOUT, 16, max cycles in XFER before forced abort (>=2)

Ports:
PCLK  in  1  clock, all logic on rising edge
PRESET  in  1  synchronous, active-high reset
req  in  NREQ  per-requester request level
req_rd  in  NREQ  per-requester direction, 1=read 0=write
req_addr  in  NREQ*ADDR_W  packed addresses, requester k at [k*ADDR_W +: ADDR_W]
req_wdata  in  NREQ*DATA_W  packed write data
gnt  out  NREQ  one-hot grant, held for the whole transaction
done  out  NREQ  one-cycle completion pulse to the granted requester
rdata  out  DATA_W  read data of the last completed read
err  out  1  error status of the last completed transaction (PSLVERR or timeout)
tmo  out  1  1 if the last completion was a timeout
transfer  out  1  to master: transaction request
READ_WRITE  out  1  to master: 1=read 0=write
apb_write_paddr  out  ADDR_W  to master
apb_write_data  out  DATA_W  to master
apb_read_paddr  out  ADDR_W  to master
m_done  in  1  from master: access phase completed this cycle (PENABLE&PREADY)
PSLVERR  in  1  from master, valid when m_done=1
apb_read_data_out  in  DATA_W  from master, valid when m_done=1

Behaviour:
- All outputs are registered.
- Reset values:
  - All outputs are 0.
  - State is IDLE.
  - Priority pointer ptr=NREQ-1, so requester 0 wins first.
  - Timer is 0.
- States: IDLE, XFER, DONE.
- IDLE, when any req bit is set:
  - Winner is the first set bit scanning ptr+1, ptr+2, ... modulo NREQ.
  - Next cycle: gnt=onehot(winner), transfer=1, READ_WRITE=req_rd[winner].
  - Both apb_write_paddr and apb_read_paddr = req_addr[winner]; apb_write_data = req_wdata[winner].
  - ptr=winner; timer=0; go to XFER.
  - Latency req->transfer is 1 cycle.
- IDLE with no req: outputs are held at 0, except rdata, err and tmo, which hold their last values.
- XFER:
  - Master-facing outputs are frozen at the latched values, independent of req, req_addr and req_wdata changes.
  - Timer increments each cycle.
  - If m_done=1: capture err=PSLVERR and tmo=0. If READ_WRITE=1, rdata=apb_read_data_out; writes leave rdata unchanged. Then go to DONE.
  - Else if timer==TIMEOUT-1: err=1, tmo=1, rdata unchanged, go to DONE.
  - If m_done and the timeout coincide in the same cycle, m_done wins (tmo=0).
- DONE (exactly 1 cycle):
  - done[winner]=1, transfer=0, gnt=0, next state IDLE.
  - rdata, err and tmo are valid with the done pulse.
- Bus spacing: at least 2 cycles with transfer=0 between transactions (DONE plus IDLE arbitration), so the master returns to its IDLE state.
- Requester protocol:
  - Hold req and its command stable until done.
  - Dropping req during XFER does not abort; the transaction completes and done still pulses.
  - Keeping req high after done makes a new request, arbitrated fairly: it wins again only if no other requester is pending.
- Fairness: with all requesters asserted continuously, grants rotate 0,1,...,NREQ-1,0.
- PRESET mid-transaction: the next cycle all outputs are 0, state is IDLE, ptr=NREQ-1, and no done pulse is issued.
- gnt and done are never multi-hot; done is never asserted outside DONE.

Test Plan:
- Single write: req[1]=1, req_rd=0, addr=9'h005, wdata=8'hAA, m_done 3 cycles after transfer rises -> transfer high 1 cycle after req; gnt=4'b0010; apb_write_paddr=5, data=AA; done[1] pulses 1 cycle after m_done; err=0.
- Read to slave 2: req[0], req_rd=1, addr=9'h103, master returns 8'h3C with m_done -> rdata=8'h3C, READ_WRITE=1 during XFER, done[0] pulse, err=0, tmo=0.
- Round-robin: req=4'b1111 held for 4 transactions -> grant order 0,1,2,3; then req=4'b1001 -> next grant 0, then 3.
- Slave error and timeout: m_done with PSLVERR=1 -> err=1, tmo=0. Next transaction with m_done never asserted -> done after exactly TIMEOUT=16 XFER cycles with err=1, tmo=1, rdata unchanged.
- Robustness:
  - req_addr changed and req dropped mid-XFER -> master-facing outputs unchanged and done still issued.
  - PRESET asserted in XFER -> all outputs 0 next cycle, no done.
  - After reset, req=4'b0110 -> grant 1.
